wb_write_arbiter: RTL
=====================

# wb_write_arbiter

Shares the register-file write port between the write-back stage result and a long-latency result source (multiply/divide unit or late load return). Pipeline write-back always has priority. Long-latency results are held in a small valid-tagged FIFO and written in free write-back slots. A starvation counter forces a one-cycle pipeline stall when a buffered result waits too long. The block sits between the write-back stage output and the register file write port.

## Interface
- DATA_WIDTH, 32, result width
- REG_ADDR_WIDTH, 5, register index width
- FIFO_DEPTH, 2, long-latency buffer entries (power of two, ≥2)
- STARVE_LIMIT, 8, cycles a non-empty FIFO may go without a grant before forcing a stall
- Clocking: one clock; reset is asynchronous and active-low.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_RegWriteW  in  1  write-back stage write enable
- i_WriteRegW  in  REG_ADDR_WIDTH  write-back destination register
- i_ResultW  in  DATA_WIDTH  write-back result
- i_LLValid  in  1  long-latency result valid
- i_LLWriteReg  in  REG_ADDR_WIDTH  long-latency destination register
- i_LLData  in  DATA_WIDTH  long-latency result
- o_LLReady  out  1  FIFO can accept; equals !full
- o_RegWrite  out  1  register-file write enable
- o_WriteReg  out  REG_ADDR_WIDTH  register-file write address
- o_WriteData  out  DATA_WIDTH  register-file write data
- o_StallW  out  1  hold the write-back stage this cycle

## Operation
- Pipeline slot is busy when i_RegWriteW=1 and i_WriteRegW≠0. A write to $0 counts as free, and o_RegWrite stays 0 for it.
- FIFO entry holds {valid, reg, data}. A push happens on i_LLValid && o_LLReady. A push to $0 is stored invalid.
- WAW squash: when the pipeline slot is busy with register X, every stored entry with reg=X is cleared to invalid. This includes an entry being pushed in the same cycle. The pipeline instruction is always the younger writer.
- Invalid head entries pop without using the write port: one pop per cycle, no grant needed.
- FSM states:
  - IDLE: FIFO empty. Enter DRAIN on push.
  - DRAIN: when the pipeline slot is free and the head is valid, grant the head (o_Reg* = head) and pop. Return to IDLE when the FIFO becomes empty. Enter FORCE when the starve counter reaches STARVE_LIMIT−1 and the head is still not granted.
  - FORCE: one cycle. o_StallW=1, grant the head regardless of the pipeline slot, pop. The pipeline write is suppressed this cycle and reappears next cycle because W is held. Next state is DRAIN if entries remain, else IDLE.
- Starve counter:
  - Increments each DRAIN cycle with a valid head and no grant.
  - Clears on any grant, on any pop, or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Otherwise o_Reg* follow the pipeline inputs combinationally.

## Timing
- Reset values:
  - FIFO empty and all entries invalid.
  - State IDLE, counter 0.
  - o_StallW=0, o_RegWrite = pipeline pass-through (0 for $0 or RegWrite=0).
  - o_LLReady=0 while i_rst_n=0, 1 from the first cycle after release.
- Pipeline path: 0-cycle combinational.
- Long-latency path: a result pushed at edge N is written no earlier than cycle N+1.
- Full FIFO: o_LLReady=0 even if a pop occurs the same cycle (registered, no pass-through). The producer must hold i_LLValid/data until accepted.
- Push and pop in the same cycle on a non-full FIFO: both occur, and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Reset asserted mid-operation: buffered entries are discarded and the stall drops immediately (asynchronous).
- Maximum stall: 1 cycle per STARVE_LIMIT cycles of contention.

## Structure
- Package wb_arb_pkg holds:
  - state enum {IDLE, DRAIN, FORCE}
  - entry struct {valid, reg, data}, parameterized widths via localparams
  - the $0 constant
- Sub-module wb_ll_fifo: circular buffer with per-entry valid bits. It has a squash-by-address port and exposes head, empty, full and count.
- FSM, counter and output mux live in wb_write_arbiter.

## Test plan
- Free slot: LL push r5=0xDEADBEEF while i_RegWriteW=0 -> next cycle o_RegWrite=1, o_WriteReg=5, o_WriteData=0xDEADBEEF, FSM returns to IDLE.
- Contention: pipeline writes r1..r3 continuously and LL pushes r7 -> no LL write until cycle STARVE_LIMIT. Then o_StallW=1 for exactly one cycle with r7 written, and the pipeline write of the held instruction follows the next cycle.
- Full: push 2 entries while the pipeline is busy -> o_LLReady=0. A third i_LLValid is held and not accepted until a pop, then accepted the following cycle.
- WAW squash: FIFO holds r9=0x11, pipeline writes r9=0x22 -> register file sees only 0x22. The r9 entry pops silently with no o_RegWrite.
- $0: LL push to r0 and pipeline write to r0 -> o_RegWrite never 1, FIFO empties within 1 cycle.
- Reset mid-FORCE: drop i_rst_n while o_StallW=1 -> o_StallW=0 immediately, FIFO empty. After release o_LLReady=1 and state IDLE.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the write-back port arbiter
//   state_t  : arbiter FSM states
//   entry_t  : long-latency buffer entry {valid, rd, data} at default widths
//   REG_ZERO : the hard-wired zero register index
package wb_arb_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef enum logic [1:0] {IDLE, DRAIN, FORCE} state_t;
  typedef struct packed {
    logic valid;
    logic [REG_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/wb_ll_fifo.sv
// wb_ll_fifo: circular buffer of long-latency results with per-entry valid bits
//   clk, rst_n            : clock, asynchronous active-low reset
//   push, push_valid      : write an entry; push_valid is its initial valid tag
//   push_reg, push_data   : destination register and result of the pushed entry
//   pop                   : retire the head entry
//   squash, squash_reg    : invalidate every entry (incl. the one being pushed) targeting squash_reg
//   head_valid/reg/data   : head entry (head_valid is 0 when empty)
//   empty, full, count    : occupancy
module wb_ll_fifo import wb_arb_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          push_valid,
  input  logic [REG_ADDR_WIDTH-1:0]     push_reg,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  input  logic                          squash,
  input  logic [REG_ADDR_WIDTH-1:0]     squash_reg,
  output logic                          head_valid,
  output logic [REG_ADDR_WIDTH-1:0]     head_reg,
  output logic [DATA_WIDTH-1:0]         head_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH-1:0] valid;
  logic [REG_ADDR_WIDTH-1:0] regs [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data [FIFO_DEPTH];
  logic push_keep;
  // the pipeline instruction is the younger writer, so an entry arriving in the
  // same cycle as a write to the same register is dead on arrival
  assign push_keep = push_valid && !(squash && push_reg == squash_reg);
  assign empty = count == '0;
  assign full = count == CW'(FIFO_DEPTH);
  assign head_valid = !empty && valid[rd_ptr];
  assign head_reg = regs[rd_ptr];
  assign head_data = data[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (squash && regs[i] == squash_reg) valid[i] <= 1'b0;
      if (push) valid[wr_ptr] <= push_keep;
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      regs[wr_ptr] <= push_reg;
      data[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register-file write port between write-back and long-latency results
//   i_clk, i_rst_n                        : clock, asynchronous active-low reset
//   i_RegWriteW, i_WriteRegW, i_ResultW   : write-back stage write (always has priority)
//   i_LLValid, i_LLWriteReg, i_LLData     : long-latency result, held by producer until accepted
//   o_LLReady                             : buffer can accept a long-latency result
//   o_RegWrite, o_WriteReg, o_WriteData   : register-file write port
//   o_StallW                              : hold the write-back stage this cycle
module wb_write_arbiter import wb_arb_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_RegWriteW,
  input  logic [REG_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic [DATA_WIDTH-1:0]     i_ResultW,
  input  logic                      i_LLValid,
  input  logic [REG_ADDR_WIDTH-1:0] i_LLWriteReg,
  input  logic [DATA_WIDTH-1:0]     i_LLData,
  output logic                      o_LLReady,
  output logic                      o_RegWrite,
  output logic [REG_ADDR_WIDTH-1:0] o_WriteReg,
  output logic [DATA_WIDTH-1:0]     o_WriteData,
  output logic                      o_StallW
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_t state, state_nx;
  logic [SW-1:0] starve, starve_nx;
  logic [CW-1:0] count, count_nx;
  logic rdy, busy, push, pop, grant, force_hit, head_squash;
  logic head_valid, empty, full;
  logic [REG_ADDR_WIDTH-1:0] head_reg;
  logic [DATA_WIDTH-1:0] head_data;
  assign busy = i_RegWriteW && i_WriteRegW != REG_ADDR_WIDTH'(REG_ZERO);
  assign o_LLReady = rdy && !full;
  assign push = i_LLValid && o_LLReady;
  assign grant = head_valid && (state == FORCE || (state == DRAIN && !busy));
  // invalid heads retire without touching the write port
  assign pop = !empty && (grant || !head_valid);
  assign count_nx = count + CW'(push) - CW'(pop);
  assign head_squash = busy && head_reg == i_WriteRegW;
  // force once the counter is about to reach STARVE_LIMIT-1, unless the head is
  // being killed this cycle (it will then retire silently next cycle)
  assign force_hit = state == DRAIN && head_valid && !grant && !head_squash &&
                     int'(starve) + 1 >= STARVE_LIMIT - 1;
  wb_ll_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .push(push),
    .push_valid(i_LLWriteReg != REG_ADDR_WIDTH'(REG_ZERO)),
    .push_reg(i_LLWriteReg),
    .push_data(i_LLData),
    .pop(pop),
    .squash(busy),
    .squash_reg(i_WriteRegW),
    .head_valid(head_valid),
    .head_reg(head_reg),
    .head_data(head_data),
    .empty(empty),
    .full(full),
    .count(count)
  );
  // rdy keeps o_LLReady low throughout reset and until the first edge after release
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      starve <= '0;
      rdy <= 1'b0;
    end else begin
      state <= state_nx;
      starve <= starve_nx;
      rdy <= 1'b1;
    end
  always_comb begin
    state_nx = (state == IDLE) ? (push ? DRAIN : IDLE)
             : (state == DRAIN && force_hit) ? FORCE
             : (count_nx == '0) ? IDLE : DRAIN;
    starve_nx = (pop || empty) ? '0
              : (state == DRAIN && head_valid && int'(starve) < STARVE_LIMIT) ? starve + 1'b1
              : starve;
  end
  // during FORCE the held pipeline write is dropped; it is presented again next cycle
  always_comb begin
    o_StallW = state == FORCE;
    o_RegWrite = grant || (busy && state != FORCE);
    o_WriteReg = grant ? head_reg : i_WriteRegW;
    o_WriteData = grant ? head_data : i_ResultW;
  end
endmodule
